cp0_gen2: RTL and testbench

CP0_GEN2 -- requirements
Module: cp0_gen2

---
 rtl/cp0_gen2_pkg.sv | 37 +++
 rtl/cp0_timer.sv | 36 +++
 rtl/cp0_gen2.sv | 166 ++++++++++++++++
 tb/tb_cp0_gen2.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_gen2_pkg.sv
// CP0 shared definitions: register numbers, exception codes
// and the SR/Cause field positions used across the CP0 slice.
package cp0_gen2_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5
  } exc_code_e;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Address-error exceptions are the ones that record BadVAddr.
  function automatic logic is_addr_exc(
    input logic [4:0] code
  );
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer. Ports: clk, reset, count_we, compare_we, Din
// in; Count, Compare and the pending flag TI out.
module cp0_timer
  import cp0_gen2_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] Din,
  output logic [31:0] Count,
  output logic [31:0] Compare,
  output logic        TI
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Count   <= '0;
      Compare <= COMPARE_RST;
      TI      <= 1'b0;
    end else begin
      Count <= count_we ? Din : Count + 32'd1;
      if (compare_we) begin
        Compare <= Din;
      end
      // Writing Compare acknowledges the timer and
      // beats a match seen on the same edge.
      if (compare_we) begin
        TI <= 1'b0;
      end else if (Count == Compare) begin
        TI <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_gen2.sv
// Coprocessor 0: SR/Cause/EPC/BadVAddr/PRId, optional timer, Req.
// In: A1/A2 reg numbers, Din/WE, PC, ExcCodeIn, VAddr, HWInt, EXLClr.
module cp0_gen2 #(
  parameter int          NUM_HWINT = 6,
  parameter int          TIMER_EN  = 1,
  parameter logic [31:0] PRID_VAL  = 32'h2002_0907
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           A1,
  input  logic [4:0]           A2,
  input  logic [31:0]          Din,
  input  logic                 WE,
  input  logic [31:0]          PC,
  input  logic                 isInDelaySlot,
  input  logic [4:0]           ExcCodeIn,
  input  logic [31:0]          VAddr,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic                 Req,
  output logic [31:0]          EPCOut,
  output logic [31:0]          DOut,
  output logic                 TimerIrq
);

  import cp0_gen2_pkg::*;

  logic [NUM_HWINT-1:0] im;
  logic [NUM_HWINT-1:0] ip;
  logic [NUM_HWINT-1:0] eff;
  logic [NUM_HWINT-1:0] ti_vec;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [4:0]           exc_code;
  logic [29:0]          epc;
  logic [29:0]          epc_new;
  logic [31:0]          bad_vaddr;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic                 ti;
  logic                 int_hit;
  logic                 exc_hit;
  logic                 wr;
  logic                 sr_we;
  logic                 epc_we;
  logic                 count_we;
  logic                 compare_we;
  logic [31:0]          sr_rd;
  logic [31:0]          cause_rd;
  logic                 unused_pc;

  assign unused_pc = ^PC[1:0];

  // Timer pending shares the top interrupt line.
  always_comb begin
    ti_vec = '0;
    ti_vec[NUM_HWINT-1] = ti;
    eff = HWInt | ti_vec;
  end

  assign int_hit = ie & (|(eff & im));
  assign exc_hit = (ExcCodeIn != 5'd0);
  assign Req     = ~exl & (int_hit | exc_hit);

  // Delay-slot victims restart at the branch.
  assign epc_new = PC[31:2] - {29'd0, isInDelaySlot};
  assign EPCOut  = {Req ? epc_new : epc, 2'b00};

  // A write landing on an exception edge is dropped.
  assign wr         = WE & ~Req;
  assign sr_we      = wr & (A2 == CP0_SR);
  assign epc_we     = wr & (A2 == CP0_EPC);
  assign count_we   = wr & (A2 == CP0_COUNT);
  assign compare_we = wr & (A2 == CP0_COMPARE);

  if (TIMER_EN != 0) begin : g_timer
    cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (count_we),
      .compare_we (compare_we),
      .Din        (Din),
      .Count      (count),
      .Compare    (compare),
      .TI         (ti)
    );
  end else begin : g_no_timer
    logic unused_timer;
    assign unused_timer = count_we ^ compare_we;
    assign count   = '0;
    assign compare = COMPARE_RST;
    assign ti      = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (sr_we) begin
        im <= Din[SR_IM_LO +: NUM_HWINT];
        ie <= Din[SR_IE];
      end
      // Exception entry beats eret, eret beats a written EXL.
      priority case (1'b1)
        Req:     exl <= 1'b1;
        EXLClr:  exl <= 1'b0;
        sr_we:   exl <= Din[SR_EXL];
        default: exl <= exl;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip        <= '0;
      bd        <= 1'b0;
      exc_code  <= EXC_INT;
      epc       <= '0;
      bad_vaddr <= '0;
    end else begin
      ip <= eff;
      if (Req) begin
        bd       <= isInDelaySlot;
        exc_code <= int_hit ? EXC_INT : ExcCodeIn;
        epc      <= epc_new;
      end else if (epc_we) begin
        epc <= Din[31:2];
      end
      if (Req & ~int_hit & is_addr_exc(ExcCodeIn)) begin
        bad_vaddr <= VAddr;
      end
    end
  end

  always_comb begin
    sr_rd = '0;
    sr_rd[SR_IM_LO +: NUM_HWINT] = im;
    sr_rd[SR_EXL] = exl;
    sr_rd[SR_IE]  = ie;
    cause_rd = '0;
    cause_rd[CAUSE_BD] = bd;
    cause_rd[CAUSE_TI] = ti;
    cause_rd[CAUSE_IP_LO +: NUM_HWINT] = ip;
    cause_rd[CAUSE_EXC_LO +: 5] = exc_code;
  end

  always_comb begin
    DOut = '0;
    unique case (A1)
      CP0_BADVADDR: DOut = bad_vaddr;
      CP0_COUNT:    DOut = count;
      CP0_COMPARE:  DOut = compare;
      CP0_SR:       DOut = sr_rd;
      CP0_CAUSE:    DOut = cause_rd;
      CP0_EPC:      DOut = EPCOut;
      CP0_PRID:     DOut = PRID_VAL;
      default:      DOut = '0;
    endcase
  end

  assign TimerIrq = ti;

endmodule

// File: tb/tb_cp0_gen2.sv
// Bench for cp0_gen2: directed literal checks then random traffic
// compared every cycle against a register-level model.
module tb_cp0_gen2;

  localparam int          N    = 6;
  localparam logic [31:0] PRID = 32'h2002_0907;
  localparam logic [31:0] IM_MASK = 32'(((1 << N) - 1) << 10);
  localparam logic [31:0] SR_MASK = IM_MASK | 32'h3;

  logic          clk;
  logic          reset;
  logic [4:0]    A1;
  logic [4:0]    A2;
  logic [31:0]   Din;
  logic          WE;
  logic [31:0]   PC;
  logic          isInDelaySlot;
  logic [4:0]    ExcCodeIn;
  logic [31:0]   VAddr;
  logic [N-1:0]  HWInt;
  logic          EXLClr;
  logic          Req;
  logic [31:0]   EPCOut;
  logic [31:0]   DOut;
  logic          TimerIrq;

  int            errors = 0;
  int            checks = 0;
  logic          chk_on = 1'b0;
  logic [31:0]   v;

  cp0_gen2 #(
    .NUM_HWINT (N),
    .TIMER_EN  (1),
    .PRID_VAL  (PRID)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .A1            (A1),
    .A2            (A2),
    .Din           (Din),
    .WE            (WE),
    .PC            (PC),
    .isInDelaySlot (isInDelaySlot),
    .ExcCodeIn     (ExcCodeIn),
    .VAddr         (VAddr),
    .HWInt         (HWInt),
    .EXLClr        (EXLClr),
    .Req           (Req),
    .EPCOut        (EPCOut),
    .DOut          (DOut),
    .TimerIrq      (TimerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: whole architectural registers as 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_compare;
  logic        m_ti;
  logic [31:0] n_sr, n_cause, n_epc, n_bad, n_count, n_compare;
  logic        n_ti;
  logic [31:0] eff, epc_c, epcout_m, dout_m;
  logic        intr, req_m, wr;

  always_comb begin
    eff      = 32'(HWInt) | (m_ti ? (32'd1 << (N - 1)) : 32'd0);
    intr     = m_sr[0] && (((eff << 10) & m_sr & IM_MASK) != 32'd0);
    req_m    = !m_sr[1] && (intr || (ExcCodeIn != 5'd0));
    epc_c    = {PC[31:2], 2'b00} - (isInDelaySlot ? 32'd4 : 32'd0);
    epcout_m = req_m ? epc_c : m_epc;
    wr       = WE && !req_m;
    case (A1)
      5'd8:    dout_m = m_bad;
      5'd9:    dout_m = m_count;
      5'd11:   dout_m = m_compare;
      5'd12:   dout_m = m_sr;
      5'd13:   dout_m = m_cause | (m_ti ? 32'h4000_0000 : 32'd0);
      5'd14:   dout_m = epcout_m;
      5'd15:   dout_m = PRID;
      default: dout_m = 32'd0;
    endcase
    n_count   = (wr && A2 == 5'd9) ? Din : m_count + 32'd1;
    n_compare = (wr && A2 == 5'd11) ? Din : m_compare;
    n_ti      = (wr && A2 == 5'd11) ? 1'b0 :
                (m_count == m_compare) ? 1'b1 : m_ti;
    n_cause   = (m_cause & ~IM_MASK) | ((eff << 10) & IM_MASK);
    if (req_m) begin
      n_cause[31]  = isInDelaySlot;
      n_cause[6:2] = intr ? 5'd0 : ExcCodeIn;
    end
    n_epc = req_m ? epc_c :
            (wr && A2 == 5'd14) ? {Din[31:2], 2'b00} : m_epc;
    n_bad = (req_m && !intr && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5))
            ? VAddr : m_bad;
    n_sr  = (wr && A2 == 5'd12) ? (Din & SR_MASK) : m_sr;
    if (req_m) n_sr[1] = 1'b1;
    else if (EXLClr) n_sr[1] = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sr      <= 32'd0;
      m_cause   <= 32'd0;
      m_epc     <= 32'd0;
      m_bad     <= 32'd0;
      m_count   <= 32'd0;
      m_compare <= 32'hFFFF_FFFF;
      m_ti      <= 1'b0;
    end else begin
      m_sr      <= n_sr;
      m_cause   <= n_cause;
      m_epc     <= n_epc;
      m_bad     <= n_bad;
      m_count   <= n_count;
      m_compare <= n_compare;
      m_ti      <= n_ti;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("Req", 32'(Req), 32'(req_m));
      chk("EPCOut", EPCOut, epcout_m);
      chk("DOut", DOut, dout_m);
      chk("TimerIrq", 32'(TimerIrq), 32'(m_ti));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] val);
    A1 = r;
    #1;
    val = DOut;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    WE = 1'b1; A2 = r; Din = d;
    cyc();
    WE = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; A1 = '0; A2 = '0; Din = '0; WE = 1'b0;
    PC = '0; isInDelaySlot = 1'b0; ExcCodeIn = '0; VAddr = '0;
    HWInt = '0; EXLClr = 1'b0;
    #1 reset = 1'b1;
    cyc();
    rd(5'd12, v); chk("rst SR", v, 32'd0);
    rd(5'd13, v); chk("rst Cause", v, 32'd0);
    rd(5'd14, v); chk("rst EPC", v, 32'd0);
    cyc();
    rd(5'd8, v);  chk("rst BadVAddr", v, 32'd0);
    rd(5'd9, v);  chk("rst Count", v, 32'd0);
    rd(5'd11, v); chk("rst Compare", v, 32'hFFFF_FFFF);
    cyc();
    rd(5'd15, v); chk("rst PRId", v, PRID);
    chk("rst TimerIrq", 32'(TimerIrq), 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // Interrupt entry.
    cyc();
    mtc0(5'd12, 32'h0000_0401);
    HWInt = N'(1); PC = 32'h0000_3010;
    #1;
    chk("int Req", 32'(Req), 32'd1);
    chk("int EPCOut", EPCOut, 32'h0000_3010);
    cyc();
    HWInt = '0;
    rd(5'd13, v); chk("int ExcCode", {27'd0, v[6:2]}, 32'd0);
    rd(5'd12, v); chk("int SR", v, 32'h0000_0403);
    rd(5'd14, v); chk("int EPC", v, 32'h0000_3010);

    // AdEL in a delay slot.
    cyc(); EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    ExcCodeIn = 5'd4; VAddr = 32'h0000_1003;
    PC = 32'h0000_3020; isInDelaySlot = 1'b1;
    #1;
    chk("adel Req", 32'(Req), 32'd1);
    chk("adel EPCOut", EPCOut, 32'h0000_301C);
    cyc();
    ExcCodeIn = '0; isInDelaySlot = 1'b0;
    rd(5'd14, v); chk("adel EPC", v, 32'h0000_301C);
    rd(5'd13, v);
    chk("adel BD", {31'd0, v[31]}, 32'd1);
    chk("adel ExcCode", {27'd0, v[6:2]}, 32'd4);
    rd(5'd8, v);  chk("adel BadVAddr", v, 32'h0000_1003);

    // Req against a same-cycle SR write and against eret.
    cyc(); EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    ExcCodeIn = 5'd5; VAddr = 32'h0000_2005;
    WE = 1'b1; A2 = 5'd12; Din = 32'd0;
    #1;
    chk("wr Req", 32'(Req), 32'd1);
    cyc();
    WE = 1'b0; ExcCodeIn = '0;
    rd(5'd12, v); chk("wr SR kept", v, 32'h0000_0403);
    rd(5'd8, v);  chk("ades BadVAddr", v, 32'h0000_2005);
    cyc(); EXLClr = 1'b1; cyc();
    ExcCodeIn = 5'd4;
    #1;
    chk("eret Req", 32'(Req), 32'd1);
    cyc();
    EXLClr = 1'b0; ExcCodeIn = '0;
    rd(5'd12, v); chk("eret EXL", v, 32'h0000_0403);
    cyc(); EXLClr = 1'b1; cyc(); EXLClr = 1'b0;

    // Count wrap.
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); chk("cnt max", v, 32'hFFFF_FFFF);
    cyc();
    rd(5'd9, v); chk("cnt wrap", v, 32'd0);

    // Timer match, interrupt, acknowledge.
    cyc();
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (5) cyc();
    chk("ti early", 32'(TimerIrq), 32'd0);
    cyc();
    chk("ti set", 32'(TimerIrq), 32'd1);
    chk("ti no Req", 32'(Req), 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    #1;
    chk("ti Req", 32'(Req), 32'd1);
    cyc();
    rd(5'd13, v);
    chk("ti Cause.TI", {31'd0, v[30]}, 32'd1);
    chk("ti ExcCode", {27'd0, v[6:2]}, 32'd0);
    mtc0(5'd11, 32'h0000_0100);
    chk("ti clr", 32'(TimerIrq), 32'd0);

    // Reset between edges with EXL set.
    cyc();
    reset = 1'b1;
    #1;
    chk("arst TimerIrq", 32'(TimerIrq), 32'd0);
    chk("arst Req", 32'(Req), 32'd0);
    rd(5'd12, v); chk("arst SR", v, 32'd0);
    rd(5'd11, v); chk("arst Compare", v, 32'hFFFF_FFFF);
    rd(5'd15, v); chk("arst PRId", v, PRID);
    #1 reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      WE = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0:       A2 = 5'd9;
        1:       A2 = 5'd11;
        2:       A2 = 5'd12;
        3:       A2 = 5'd14;
        default: A2 = 5'($urandom);
      endcase
      Din = $urandom;
      if (A2 == 5'd11 && $urandom_range(0, 1) == 1)
        Din = m_count + 32'($urandom_range(2, 40));
      A1 = 5'($urandom);
      HWInt = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      case ($urandom_range(0, 9))
        0:       ExcCodeIn = 5'd4;
        1:       ExcCodeIn = 5'd5;
        2:       ExcCodeIn = 5'($urandom);
        default: ExcCodeIn = 5'd0;
      endcase
      EXLClr = ($urandom_range(0, 2) == 0);
      PC = $urandom;
      VAddr = $urandom;
      isInDelaySlot = 1'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
